// File: rtl/mrmac_0_axis_pkg.sv
// Shared types and widths for the MRMAC RX AXIS packet FIFO.
// One RAM word holds a whole 128b beat plus its byte enables and tlast.
package mrmac_0_axis_pkg;

    localparam int unsigned LANES       = 2;
    localparam int unsigned LANE_W      = 64;
    localparam int unsigned MAC_KEEP_W  = 11;
    localparam int unsigned BYTE_KEEP_W = 8;
    localparam int unsigned DATA_W      = LANES * LANE_W;
    localparam int unsigned KEEP_W      = LANES * BYTE_KEEP_W;

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } rx_beat_t;

    localparam int unsigned BEAT_W = $bits(rx_beat_t);

    typedef enum logic [1:0] {
        WR_SYNC,
        WR_PASS,
        WR_DROP
    } wr_state_e;

endpackage

// File: rtl/mrmac_0_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// No read-during-write bypass; the FIFO never reads an address being written.
module mrmac_0_sdp_ram #(
    parameter  int unsigned WIDTH = 145,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mrmac_0_axis_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: MRMAC RX AXIS (no backpressure) in, whole
// error-free packets out over AXIS with tready; overflow and bad-FCS packets dropped.
module mrmac_0_axis_rx_pkt_fifo
    import mrmac_0_axis_pkg::*;
#(
    parameter  int unsigned DEPTH = 512,
    parameter  int unsigned CNT_W = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rx_tvalid,
    input  logic [LANES-1:0][LANE_W-1:0]        rx_tdata,
    input  logic [LANES-1:0][MAC_KEEP_W-1:0]    rx_tkeep,
    input  logic                                rx_tlast,
    input  logic                                rx_tuser,
    output logic                                m_tvalid,
    output logic [DATA_W-1:0]                   m_tdata,
    output logic [KEEP_W-1:0]                   m_tkeep,
    output logic                                m_tlast,
    input  logic                                m_tready,
    output logic [CNT_W-1:0]                    stat_pkt_cnt,
    output logic [CNT_W-1:0]                    stat_ovf_drop_cnt,
    output logic [CNT_W-1:0]                    stat_err_drop_cnt,
    output logic [PTR_W-1:0]                    fifo_level
);

    localparam int unsigned AW = PTR_W - 1;

    wr_state_e        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] cm_ptr_q, cm_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] ra_ptr_q, ra_ptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             ram_vld_q, ram_vld_d;
    logic             m_tvalid_q, m_tvalid_d;
    rx_beat_t         out_q, out_d;

    rx_beat_t wr_beat;
    rx_beat_t ram_rdata;
    logic     ram_we;
    logic     ram_re;
    logic     full;
    logic     keep_rsvd_unused;

    // Pack MAC lanes into one RAM word; reserved keep bits are dropped here.
    always_comb begin
        wr_beat          = '0;
        keep_rsvd_unused = 1'b0;
        wr_beat.data     = rx_tdata;
        wr_beat.last     = rx_tlast;
        for (int l = 0; l < LANES; l++) begin
            wr_beat.keep[l*BYTE_KEEP_W +: BYTE_KEEP_W] = rx_tkeep[l][BYTE_KEEP_W-1:0];
            keep_rsvd_unused ^= ^rx_tkeep[l][MAC_KEEP_W-1:BYTE_KEEP_W];
        end
    end

    // rd_ptr only advances on a user handshake, so prefetched beats still hold space.
    assign full = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);

    // Write FSM: speculative write, commit on good tlast, rewind on error/overflow.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cm_ptr_d  = cm_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        err_cnt_d = err_cnt_q;
        ram_we    = 1'b0;
        if (rx_tvalid) begin
            unique case (state_q)
                WR_SYNC: begin
                    if (rx_tlast) begin
                        state_d = WR_PASS;
                    end
                end
                WR_PASS: begin
                    if (full) begin
                        wr_ptr_d = cm_ptr_q;
                        if (rx_tlast) begin
                            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                        end else begin
                            state_d = WR_DROP;
                        end
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        if (rx_tlast) begin
                            if (rx_tuser) begin
                                wr_ptr_d  = cm_ptr_q;
                                err_cnt_d = err_cnt_q + CNT_W'(1);
                            end else begin
                                cm_ptr_d  = wr_ptr_q + PTR_W'(1);
                                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                WR_DROP: begin
                    if (rx_tlast) begin
                        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                        state_d   = WR_PASS;
                    end
                end
                default: state_d = WR_SYNC;
            endcase
        end
    end

    // Read side: RAM output stage feeds the AXIS output register one beat ahead.
    always_comb begin
        logic out_load;
        logic hs;
        hs         = m_tvalid_q && m_tready;
        out_load   = ram_vld_q && (!m_tvalid_q || m_tready);
        ram_re     = (ra_ptr_q != cm_ptr_q) && (!ram_vld_q || out_load);
        ra_ptr_d   = ram_re ? ra_ptr_q + PTR_W'(1) : ra_ptr_q;
        rd_ptr_d   = hs ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        ram_vld_d  = ram_re || (ram_vld_q && !out_load);
        m_tvalid_d = out_load || (m_tvalid_q && !m_tready);
        out_d      = out_load ? ram_rdata : out_q;
        level_d    = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WR_SYNC;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ra_ptr_q   <= '0;
            level_q    <= '0;
            pkt_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
            err_cnt_q  <= '0;
            ram_vld_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ra_ptr_q   <= ra_ptr_d;
            level_q    <= level_d;
            pkt_cnt_q  <= pkt_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ram_vld_q  <= ram_vld_d;
            m_tvalid_q <= m_tvalid_d;
            out_q      <= out_d;
        end
    end

    mrmac_0_sdp_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_beat),
        .re_i    (ram_re),
        .raddr_i (ra_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign m_tvalid          = m_tvalid_q;
    assign m_tdata           = out_q.data;
    assign m_tkeep           = out_q.keep;
    assign m_tlast           = out_q.last;
    assign stat_pkt_cnt      = pkt_cnt_q;
    assign stat_ovf_drop_cnt = ovf_cnt_q;
    assign stat_err_drop_cnt = err_cnt_q;
    assign fifo_level        = level_q;

endmodule
